// File: rtl/sbuffer_fwd_if.sv
// Store-buffer bus: committed-store insert, dcache drain port and the
// store-to-load forwarding request/response pipeline (s0/s1/s2).
interface sbuffer_fwd_if #(
    parameter int XLEN    = 64,
    parameter int PADDR_W = 36,
    parameter int LQ_W    = 6,
    parameter int SQ_W    = 6
);
    localparam int NB = XLEN / 8;

    // committed-store insert
    logic               st_vld;
    logic               st_rdy;
    logic [XLEN-1:0]    st_vaddr;
    logic [PADDR_W-1:0] st_paddr;
    logic [XLEN-1:0]    st_data;
    logic [NB-1:0]      st_mask;

    // drain control and dcache write port
    logic               flush;
    logic               empty;
    logic               drain_vld;
    logic               drain_rdy;
    logic [PADDR_W-1:0] drain_paddr;
    logic [XLEN-1:0]    drain_data;
    logic [NB-1:0]      drain_mask;

    // forwarding request stages
    logic               fwd_s0_vld;
    logic [LQ_W-1:0]    fwd_s0_lqIdx;
    logic [SQ_W-1:0]    fwd_s0_sqIdx;
    logic [XLEN-1:0]    fwd_s0_vaddr;
    logic [NB-1:0]      fwd_s0_load_vec;
    logic               fwd_s1_vld;
    logic [PADDR_W-1:0] fwd_s1_paddr;

    // forwarding responses
    logic               fwd_s1_vaddr_match;
    logic               fwd_s1_data_rdy;
    logic               fwd_s2_rdy;
    logic [LQ_W-1:0]    fwd_s2_lqIdx;
    logic               fwd_s2_paddr_match;
    logic               fwd_s2_match_failed;
    logic [NB-1:0]      fwd_s2_match_vec;
    logic [XLEN-1:0]    fwd_s2_fwd_data;

    modport master (
        output st_vld, st_vaddr, st_paddr, st_data, st_mask,
        output flush, drain_rdy,
        output fwd_s0_vld, fwd_s0_lqIdx, fwd_s0_sqIdx, fwd_s0_vaddr, fwd_s0_load_vec,
        output fwd_s1_vld, fwd_s1_paddr,
        input  st_rdy, empty, drain_vld, drain_paddr, drain_data, drain_mask,
        input  fwd_s1_vaddr_match, fwd_s1_data_rdy,
        input  fwd_s2_rdy, fwd_s2_lqIdx, fwd_s2_paddr_match, fwd_s2_match_failed,
        input  fwd_s2_match_vec, fwd_s2_fwd_data
    );

    modport slave (
        input  st_vld, st_vaddr, st_paddr, st_data, st_mask,
        input  flush, drain_rdy,
        input  fwd_s0_vld, fwd_s0_lqIdx, fwd_s0_sqIdx, fwd_s0_vaddr, fwd_s0_load_vec,
        input  fwd_s1_vld, fwd_s1_paddr,
        output st_rdy, empty, drain_vld, drain_paddr, drain_data, drain_mask,
        output fwd_s1_vaddr_match, fwd_s1_data_rdy,
        output fwd_s2_rdy, fwd_s2_lqIdx, fwd_s2_paddr_match, fwd_s2_match_failed,
        output fwd_s2_match_vec, fwd_s2_fwd_data
    );
endinterface

// File: rtl/sbuffer_fwd.sv
// Committed-store buffer: coalesces stores per 8-byte word, drains in
// allocation order and answers the 3-stage store-to-load forwarding pipe.
module sbuffer_fwd #(
    parameter int NENTRY       = 8,
    parameter int DRAIN_THRESH = 6,
    parameter int XLEN         = 64,
    parameter int PADDR_W      = 36,
    parameter int LQ_W         = 6
) (
    input  logic          clk,
    input  logic          rst,
    sbuffer_fwd_if.slave  bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(NENTRY);
    localparam int VW_W  = XLEN - OFF_W;
    localparam int PW_W  = PADDR_W - OFF_W;

    typedef logic [IDX_W:0] ptr_t;

    // ---------------- entry storage ----------------
    logic [NENTRY-1:0] valid_reg;
    logic [VW_W-1:0]   vword_reg [NENTRY];
    logic [PW_W-1:0]   pword_reg [NENTRY];
    logic [XLEN-1:0]   data_reg  [NENTRY];
    logic [NB-1:0]     mask_reg  [NENTRY];

    ptr_t              head_reg;
    ptr_t              tail_reg;
    ptr_t              occupancy;
    logic [IDX_W-1:0]  head_idx;
    logic [IDX_W-1:0]  tail_idx;
    logic              empty_int;
    logic              full;
    logic              at_thresh;

    logic [VW_W-1:0]   st_vword;
    logic [PW_W-1:0]   st_pword;
    logic [VW_W-1:0]   s0_vword;
    logic [PW_W-1:0]   s1_pword;

    logic [NENTRY-1:0] st_hit_vec;
    logic [NENTRY-1:0] s0_hit_vec;
    logic [NENTRY-1:0] s1_pmatch_vec;
    logic [IDX_W-1:0]  merge_idx;
    logic [IDX_W-1:0]  s0_idx;
    logic              merge_any;
    logic [XLEN-1:0]   merged_data;

    logic              drain_vld_int;
    logic              st_rdy_int;
    logic              st_fire;
    logic              drain_fire;
    logic              alloc;
    logic              merge;

    // ---------------- pipeline registers ----------------
    logic              s1_hit_reg;
    logic [IDX_W-1:0]  s1_idx_reg;
    logic [PW_W-1:0]   snap_pword_reg;
    logic [XLEN-1:0]   snap_data_reg;
    logic [NB-1:0]     snap_mask_reg;
    logic [NB-1:0]     s1_load_vec_reg;
    logic [LQ_W-1:0]   s1_lq_reg;

    logic [NB-1:0]     s1_sel;
    logic              s1_vaddr_match;
    logic              s1_any_pmatch;
    logic              s1_paddr_match;
    logic              s1_drained;
    logic              s1_failed;
    logic [NB-1:0]     s1_vec;
    logic [XLEN-1:0]   s1_fwd_data;

    logic              s2_rdy_reg;
    logic [LQ_W-1:0]   s2_lq_reg;
    logic              s2_paddr_match_reg;
    logic              s2_failed_reg;
    logic [NB-1:0]     s2_vec_reg;
    logic [XLEN-1:0]   s2_data_reg;

    logic              unused_bits;

    assign st_vword = bus.st_vaddr[XLEN-1:OFF_W];
    assign st_pword = bus.st_paddr[PADDR_W-1:OFF_W];
    assign s0_vword = bus.fwd_s0_vaddr[XLEN-1:OFF_W];
    assign s1_pword = bus.fwd_s1_paddr[PADDR_W-1:OFF_W];

    // Residents are always older than the querying load, so sqIdx carries no information.
    assign unused_bits = ^{bus.fwd_s0_sqIdx, bus.st_vaddr[OFF_W-1:0], bus.st_paddr[OFF_W-1:0],
                           bus.fwd_s0_vaddr[OFF_W-1:0], bus.fwd_s1_paddr[OFF_W-1:0]};

    assign occupancy = tail_reg - head_reg;
    assign head_idx  = head_reg[IDX_W-1:0];
    assign tail_idx  = tail_reg[IDX_W-1:0];
    assign empty_int = (occupancy == '0);
    assign full      = (occupancy == ptr_t'(NENTRY));
    assign at_thresh = (occupancy >= ptr_t'(DRAIN_THRESH));

    // ---------------- parallel compares ----------------
    generate
        for (genvar gi = 0; gi < NENTRY; gi++) begin : g_cmp
            assign st_hit_vec[gi]    = valid_reg[gi] && (pword_reg[gi] == st_pword);
            assign s0_hit_vec[gi]    = valid_reg[gi] && (vword_reg[gi] == s0_vword);
            assign s1_pmatch_vec[gi] = valid_reg[gi] && (pword_reg[gi] == s1_pword);
        end
    endgenerate

    // Both vectors are at most one-hot (one entry per word), so a plain encode suffices.
    always_comb begin
        merge_idx = '0;
        s0_idx    = '0;
        for (int i = 0; i < NENTRY; i++) begin
            if (st_hit_vec[i]) merge_idx = IDX_W'(i);
            if (s0_hit_vec[i]) s0_idx    = IDX_W'(i);
        end
    end

    assign merge_any = |st_hit_vec;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_merge
            assign merged_data[gi*8 +: 8] = bus.st_mask[gi] ? bus.st_data[gi*8 +: 8]
                                                            : data_reg[merge_idx][gi*8 +: 8];
        end
    endgenerate

    // ---------------- insert / drain control ----------------
    assign drain_vld_int = rst && !empty_int && (at_thresh || bus.flush);
    // Merging into an entry that may leave this cycle would lose the new bytes.
    assign st_rdy_int    = rst && !((!merge_any && full) ||
                                    (merge_any && (merge_idx == head_idx) && drain_vld_int));
    assign st_fire       = bus.st_vld && st_rdy_int;
    assign drain_fire    = drain_vld_int && bus.drain_rdy;
    assign alloc         = st_fire && !merge_any;
    assign merge         = st_fire && merge_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            if (drain_fire) valid_reg[head_idx] <= 1'b0;
            if (alloc)      valid_reg[tail_idx] <= 1'b1;
            head_reg <= head_reg + ptr_t'(drain_fire);
            tail_reg <= tail_reg + ptr_t'(alloc);
        end
    end

    // Payload needs no reset; valid_reg qualifies every use.
    always_ff @(posedge clk) begin
        if (alloc) begin
            vword_reg[tail_idx] <= st_vword;
            pword_reg[tail_idx] <= st_pword;
            data_reg[tail_idx]  <= bus.st_data;
            mask_reg[tail_idx]  <= bus.st_mask;
        end
        if (merge) begin
            data_reg[merge_idx] <= merged_data;
            mask_reg[merge_idx] <= mask_reg[merge_idx] | bus.st_mask;
        end
    end

    assign bus.st_rdy      = st_rdy_int;
    assign bus.empty       = rst && empty_int;
    assign bus.drain_vld   = drain_vld_int;
    assign bus.drain_paddr = drain_vld_int ? {pword_reg[head_idx], {OFF_W{1'b0}}} : '0;
    assign bus.drain_data  = drain_vld_int ? data_reg[head_idx] : '0;
    assign bus.drain_mask  = drain_vld_int ? mask_reg[head_idx] : '0;

    // ---------------- s0 -> s1 snapshot ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_hit_reg      <= 1'b0;
            s1_idx_reg      <= '0;
            snap_pword_reg  <= '0;
            snap_data_reg   <= '0;
            snap_mask_reg   <= '0;
            s1_load_vec_reg <= '0;
            s1_lq_reg       <= '0;
        end else begin
            s1_hit_reg      <= bus.fwd_s0_vld && (|s0_hit_vec);
            s1_idx_reg      <= s0_idx;
            snap_pword_reg  <= pword_reg[s0_idx];
            snap_data_reg   <= data_reg[s0_idx];
            snap_mask_reg   <= mask_reg[s0_idx];
            s1_load_vec_reg <= bus.fwd_s0_load_vec;
            s1_lq_reg       <= bus.fwd_s0_lqIdx;
        end
    end

    // ---------------- s1 evaluation ----------------
    assign s1_sel         = snap_mask_reg & s1_load_vec_reg;
    assign s1_vaddr_match = s1_hit_reg && (|s1_sel);
    assign s1_any_pmatch  = |s1_pmatch_vec;
    assign s1_paddr_match = s1_hit_reg && (snap_pword_reg == s1_pword);
    assign s1_drained     = s1_hit_reg && drain_fire && (head_idx == s1_idx_reg);
    // A vaddr hit whose entry is not the unique paddr owner means a synonym/alias.
    assign s1_failed      = (s1_hit_reg != s1_any_pmatch) || (s1_hit_reg && !s1_paddr_match) ||
                            s1_drained;
    assign s1_vec         = (s1_paddr_match && !s1_failed) ? s1_sel : '0;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_fwd
            assign s1_fwd_data[gi*8 +: 8] = s1_vec[gi] ? snap_data_reg[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign bus.fwd_s1_vaddr_match = s1_vaddr_match;
    assign bus.fwd_s1_data_rdy    = s1_vaddr_match;

    // ---------------- s2 registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_rdy_reg         <= 1'b0;
            s2_lq_reg          <= '0;
            s2_paddr_match_reg <= 1'b0;
            s2_failed_reg      <= 1'b0;
            s2_vec_reg         <= '0;
            s2_data_reg        <= '0;
        end else begin
            s2_rdy_reg         <= bus.fwd_s1_vld;
            s2_lq_reg          <= s1_lq_reg;
            s2_paddr_match_reg <= bus.fwd_s1_vld && s1_paddr_match;
            s2_failed_reg      <= bus.fwd_s1_vld && s1_failed;
            s2_vec_reg         <= bus.fwd_s1_vld ? s1_vec : '0;
            s2_data_reg        <= bus.fwd_s1_vld ? s1_fwd_data : '0;
        end
    end

    assign bus.fwd_s2_rdy          = s2_rdy_reg;
    assign bus.fwd_s2_lqIdx        = s2_lq_reg;
    assign bus.fwd_s2_paddr_match  = s2_paddr_match_reg;
    assign bus.fwd_s2_match_failed = s2_failed_reg;
    assign bus.fwd_s2_match_vec    = s2_vec_reg;
    assign bus.fwd_s2_fwd_data     = s2_data_reg;
endmodule
